// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, ALU-source and ID-stage FSM encodings
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_PUSH  = 6'b110000;
  localparam logic [5:0] OP_POP   = 6'b110001;
  localparam logic [5:0] OP_CALL  = 6'b110010;
  localparam logic [5:0] OP_RET   = 6'b110011;

  localparam logic [1:0] ALU_SRC_REG   = 2'b00;
  localparam logic [1:0] ALU_SRC_IMM   = 2'b01;
  localparam logic [1:0] ALU_SRC_CONST = 2'b10;

  typedef enum logic [1:0] {IDLE, HAZ, STK1, STK2} id_state_t;

  // Stack ops run as two micro-ops after the decode cycle
  function automatic logic is_stack_op(input logic [5:0] op);
    return (op == OP_PUSH) || (op == OP_POP) || (op == OP_CALL) || (op == OP_RET);
  endfunction

  // Anything outside the opcode map decodes as a NOP
  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ) || (op == OP_J) || is_stack_op(op);
  endfunction

  // Opcodes whose rt field is a genuine source operand
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_PUSH);
  endfunction

endpackage

// File: rtl/id_stage_ctrl.sv
// rtl/id_stage_ctrl.sv - decode control, load-use stall and stack micro-op sequencer
module id_stage_ctrl
  import cpu_pkg::*;
#(
  parameter logic [4:0] SP_REG   = 5'd29,
  parameter logic [4:0] ZERO_REG = 5'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [5:0] opcode,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic [1:0] alu_src,
  output logic       alu_const_one,
  output logic       alu_sub,
  output logic       branch,
  output logic       sign_ext_sel,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic [4:0] read_reg_1,
  output logic [4:0] read_reg_2,
  output logic       stall
);

  id_state_t  state, state_next;
  logic [5:0] op_q;
  logic       latch_op;
  logic       load_use;

  assign load_use = ex_mem_read && (ex_rd != ZERO_REG) &&
                    ((ex_rd == rs) || (reads_rt(opcode) && (ex_rd == rt)));

  // State register and stack opcode latch; reset aborts any micro-op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= '0;
    end else begin
      state <= state_next;
      if (latch_op) op_q <= opcode;
    end
  end

  // Next state and all control outputs; reset forces the quiet IDLE pattern
  always_comb begin
    state_next    = state;
    latch_op      = 1'b0;
    alu_src       = ALU_SRC_REG;
    alu_const_one = 1'b0;
    alu_sub       = 1'b0;
    branch        = 1'b0;
    sign_ext_sel  = 1'b0;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    read_reg_1    = rs;
    read_reg_2    = rt;
    stall         = 1'b0;
    if (!rst) begin
      case (state)
        IDLE, HAZ: begin
          state_next = IDLE;
          if (instr_valid && is_known_op(opcode)) begin
            // HAZ never re-checks, so one instruction stalls at most one cycle
            if ((state == IDLE) && load_use) begin
              stall      = 1'b1;
              state_next = HAZ;
            end else if (is_stack_op(opcode)) begin
              stall      = 1'b1;
              latch_op   = 1'b1;
              state_next = STK1;
            end else begin
              case (opcode)
                OP_RTYPE: reg_write = 1'b1;
                OP_ADDI, OP_ANDI: begin
                  alu_src   = ALU_SRC_IMM;
                  reg_write = 1'b1;
                end
                OP_LW: begin
                  alu_src   = ALU_SRC_IMM;
                  mem_read  = 1'b1;
                  reg_write = 1'b1;
                end
                OP_SW: begin
                  alu_src   = ALU_SRC_IMM;
                  mem_write = 1'b1;
                end
                OP_BEQ: begin
                  alu_src = ALU_SRC_IMM;
                  branch  = 1'b1;
                end
                OP_J: begin
                  branch       = 1'b1;
                  sign_ext_sel = 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        STK1: begin
          stall      = 1'b1;
          read_reg_1 = SP_REG;
          alu_src    = ALU_SRC_CONST;
          state_next = STK2;
          if ((op_q == OP_PUSH) || (op_q == OP_CALL)) begin
            alu_const_one = 1'b1;
            alu_sub       = 1'b1;
            mem_write     = 1'b1;
          end else begin
            // Pop side reads memory at the current SP, so the offset is zero
            mem_read  = 1'b1;
            reg_write = (op_q == OP_POP);
          end
        end
        STK2: begin
          read_reg_1    = SP_REG;
          alu_src       = ALU_SRC_CONST;
          alu_const_one = 1'b1;
          reg_write     = 1'b1;
          state_next    = IDLE;
          alu_sub       = (op_q == OP_PUSH) || (op_q == OP_CALL);
          branch        = (op_q == OP_CALL) || (op_q == OP_RET);
          sign_ext_sel  = (op_q == OP_CALL);
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: doc/id_stage_ctrl.md
ID_STAGE_CTRL -- requirements
Module: id_stage_ctrl

Interface
REQ-001 SHALL have parameter SP_REG, default 5'd29, meaning stack-pointer register index.
REQ-002 SHALL have parameter ZERO_REG, default 5'd0, meaning hardwired-zero register index, excluded from hazard compare.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port instr_valid  input  1  IF/ID register holds a valid instruction.
REQ-006 SHALL have port opcode  input  6  Inst[31:26].
REQ-007 SHALL have ports rs, rt  input  5 each  decoded source register fields.
REQ-008 SHALL have ports ex_mem_read  input  1 and ex_rd  input  5  load currently in EX and its destination.
REQ-009 SHALL have port alu_src  output  2  00 reg/reg, 01 reg/sign_ext, 10 reg/const, 11 unused.
REQ-010 SHALL have ports alu_const_one, alu_sub, branch, sign_ext_sel, reg_write, mem_read, mem_write  output  1 each.
REQ-011 SHALL have ports read_reg_1, read_reg_2  output  5 each  register-file read addresses.
REQ-012 SHALL have port stall  output  1  hold PC and IF/ID this cycle.

Function
REQ-013 SHALL use opcodes R-type 000000, ADDI 001000, ANDI 001100, LW 100011, SW 101011, BEQ 000100, J 000010, PUSH 110000, POP 110001, CALL 110010, RET 110011; any other opcode is a NOP.
REQ-014 SHALL implement FSM states IDLE, HAZ, STK1, STK2; outputs combinational from state and inputs; state registered.
REQ-015 SHALL, in IDLE with instr_valid=0 or NOP, drive all 1-bit outputs 0, alu_src 00, read_reg_1=rs, read_reg_2=rt, stay IDLE.
REQ-016 SHALL detect load-use when ex_mem_read=1, ex_rd!=ZERO_REG, and ex_rd equals rs, or equals rt for R-type/SW/BEQ/PUSH; then assert stall, force all write/mem/branch outputs 0 (bubble), go HAZ.
REQ-017 SHALL leave HAZ after exactly one cycle to IDLE and re-decode the held instruction; hazard check takes priority over stack sequencing.
REQ-018 SHALL decode single-cycle ops with zero stall: R-type alu_src 00, reg_write 1; ADDI/ANDI alu_src 01, reg_write 1; LW alu_src 01, mem_read 1, reg_write 1; SW alu_src 01, mem_write 1; BEQ alu_src 01, branch 1; J branch 1, sign_ext_sel 1.
REQ-019 SHALL run PUSH/POP/CALL/RET as two micro-ops: IDLE->STK1 with stall=1, STK1->STK2 with stall=1, STK2->IDLE with stall=0; total 3 cycles in ID.
REQ-020 SHALL in STK1 and STK2 drive read_reg_1=SP_REG, alu_src 10, alu_const_one 1.
REQ-021 SHALL in STK1: PUSH/CALL alu_sub 1, mem_write 1; POP/RET alu_sub 0 with const forced 0 via alu_const_one 0, mem_read 1; POP also reg_write 1 (rt).
REQ-022 SHALL in STK2: PUSH/CALL alu_sub 1, reg_write 1 (SP-1); POP/RET alu_sub 0, reg_write 1 (SP+1); CALL additionally branch 1, sign_ext_sel 1; RET additionally branch 1.
REQ-023 SHALL latch opcode on IDLE->STK1 and sequence from the latched value, ignoring opcode/instr_valid changes during STK1/STK2.
REQ-024 SHALL never stall two consecutive instructions for hazard more than one cycle each.

Reset
REQ-025 SHALL on rst=1 asynchronously enter IDLE and clear latched opcode; all outputs as REQ-015 while rst=1.
REQ-026 SHALL abort any in-flight micro-op on reset with no mem_write or reg_write asserted afterward.

Structure
REQ-027 SHALL place opcode constants, alu_src encodings, and FSM state encoding in shared package cpu_pkg.
REQ-028 SHALL be single module; no sub-module required.

Verification
REQ-029 SHALL verify ADDI rs=3, no hazard -> alu_src 01, reg_write 1, stall 0, same cycle.
REQ-030 SHALL verify ex_mem_read=1, ex_rd=4, R-type rt=4 -> stall 1 one cycle, reg_write 0, then reg_write 1.
REQ-031 SHALL verify ex_rd=0 with rs=0 -> no stall.
REQ-032 SHALL verify PUSH -> stall 1,1,0; mem_write in cycle 1, reg_write in cycle 2, read_reg_1=29 both.
REQ-033 SHALL verify CALL then rst asserted in STK1 -> IDLE immediately, mem_write/reg_write/branch 0.
REQ-034 SHALL verify opcode 111111 -> all control 0, no stall.
